// File: rtl/eth_frame_rx.sv
// Byte-stream Ethernet receiver: strips preamble/SFD, filters on dst MAC and EtherType, writes payload+FCS to the buffer, checks CRC-32.
// Buffer writes lag the input byte by 1 cycle; no backpressure (rx_dv paces everything); verdict pulses one cycle after rx_dv falls.
module eth_frame_rx #(
  parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          ADDR_W    = 11,
  parameter int          MAX_LEN   = 1504
) (
  input  logic              clk125,
  input  logic              rstn,
  input  logic              rx_dv,
  input  logic              rx_er,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [ADDR_W-1:0] frame_len,
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(MAX_LEN - 1);
  localparam logic [ADDR_W-1:0] MIN_CNT     = ADDR_W'(50);
  localparam logic [ADDR_W-1:0] FCS_LEN     = ADDR_W'(4);
  localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HEADER, S_PAYLOAD, S_DROP, S_END
  } state_t;

  state_t            state, next_state;
  logic [3:0]        hdr_cnt;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       crc, crc_next;
  logic              mac_hit, bc_hit, mac_hit_n, bc_hit_n;
  logic              hdr_bad, hdr_pass, err, ovf;
  logic [7:0]        mac_byte;
  logic              frame_pass;
  logic [ADDR_W-1:0] len_n;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  always_comb begin
    mac_byte = 8'h00;
    case (hdr_cnt)
      4'd0:    mac_byte = MAC_ADDR[47:40];
      4'd1:    mac_byte = MAC_ADDR[39:32];
      4'd2:    mac_byte = MAC_ADDR[31:24];
      4'd3:    mac_byte = MAC_ADDR[23:16];
      4'd4:    mac_byte = MAC_ADDR[15:8];
      4'd5:    mac_byte = MAC_ADDR[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // Unicast and broadcast matches are tracked separately; dst fails only once both are lost.
  always_comb begin
    mac_hit_n = mac_hit;
    bc_hit_n  = bc_hit;
    hdr_bad   = 1'b0;
    if (hdr_cnt < 4'd6) begin
      mac_hit_n = mac_hit & (rx_data == mac_byte);
      bc_hit_n  = bc_hit & (rx_data == 8'hFF);
      hdr_bad   = !mac_hit_n && !bc_hit_n;
    end else if (hdr_cnt == 4'd12) begin
      hdr_bad = (rx_data != ETHERTYPE[15:8]);
    end else if (hdr_cnt == 4'd13) begin
      hdr_bad = (rx_data != ETHERTYPE[7:0]);
    end
  end

  assign crc_next   = crc_byte(crc, rx_data);
  assign frame_pass = (crc == CRC_RESIDUE) && !err && (cnt >= MIN_CNT) && !ovf && hdr_pass;
  assign len_n      = (cnt >= FCS_LEN) ? (cnt - FCS_LEN) : '0;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (rx_dv && rx_data == 8'h55) next_state = S_PRE;
      S_PRE: begin
        if (!rx_dv)                 next_state = S_IDLE;
        else if (rx_data == 8'hD5)  next_state = S_HEADER;
        else if (rx_data != 8'h55)  next_state = S_IDLE;
      end
      S_HEADER: begin
        if (!rx_dv)                 next_state = S_END;
        else if (hdr_bad)           next_state = S_DROP;
        else if (hdr_cnt == 4'd13)  next_state = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!rx_dv)                 next_state = S_END;
        else if (cnt == LAST_IDX)   next_state = S_DROP;
      end
      S_DROP: if (!rx_dv) next_state = S_END;
      S_END:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (!rstn) begin
      state      <= S_IDLE;
      hdr_cnt    <= '0;
      cnt        <= '0;
      crc        <= 32'hFFFFFFFF;
      mac_hit    <= 1'b0;
      bc_hit     <= 1'b0;
      hdr_pass   <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      state      <= next_state;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_PRE: if (rx_dv && rx_data == 8'hD5) begin
          hdr_cnt  <= '0;
          cnt      <= '0;
          crc      <= 32'hFFFFFFFF;
          mac_hit  <= 1'b1;
          bc_hit   <= 1'b1;
          hdr_pass <= 1'b0;
          err      <= 1'b0;
          ovf      <= 1'b0;
        end
        S_HEADER: if (rx_dv) begin
          crc     <= crc_next;
          hdr_cnt <= hdr_cnt + 4'd1;
          mac_hit <= mac_hit_n;
          bc_hit  <= bc_hit_n;
          err     <= err | rx_er;
          if (hdr_cnt == 4'd13 && !hdr_bad) hdr_pass <= 1'b1;
        end
        S_PAYLOAD: if (rx_dv) begin
          crc     <= crc_next;
          wr_en   <= 1'b1;
          wr_addr <= cnt;
          wr_data <= rx_data;
          cnt     <= cnt + 1'b1;
          err     <= err | rx_er;
          if (cnt == LAST_IDX) ovf <= 1'b1;
        end
        S_DROP: if (rx_dv) err <= err | rx_er;
        default: ;
      endcase
      // Verdict registers on the edge that enters S_END so frame_done is high during S_END.
      if (next_state == S_END) begin
        frame_done <= 1'b1;
        frame_ok   <= frame_pass;
        frame_len  <= len_n;
        if (frame_pass) begin
          if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
        end else begin
          if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_rx.sv
// Directed bench for eth_frame_rx: builds frames with a reference CRC-32 and checks writes, verdicts and counters.
module tb_eth_frame_rx;

  localparam int AW = 11;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic          clk125, rstn, rx_dv, rx_er;
  logic [7:0]    rx_data;
  logic          wr_en, frame_done, frame_ok;
  logic [AW-1:0] wr_addr, frame_len;
  logic [7:0]    wr_data;
  logic [15:0]   good_cnt, bad_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0]    frm[$];
  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];
  logic          ok_q[$];
  logic [AW-1:0] len_q[$];
  int cyc = 0, done_cnt = 0, last_wr_cyc = 0, done_cyc = 0;

  eth_frame_rx dut (
    .clk125(clk125), .rstn(rstn), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_len(frame_len),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  initial clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  always @(posedge clk125) cyc++;

  always @(negedge clk125) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      ok_q.push_back(frame_ok);
      len_q.push_back(frame_len);
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] ref_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < frm.size(); i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype, input int plen);
    logic [31:0] fcs;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'(16 + i));
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    for (int i = 0; i < plen; i++) frm.push_back(8'(i));
    fcs = ref_fcs();
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
  endtask

  task automatic drive_frame(input int nbytes, input int er_pos);
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk125); #1;
      rx_dv = 1'b1; rx_data = frm[i]; rx_er = (i == er_pos);
    end
    @(posedge clk125); #1;
    rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_done(input int target, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= target) begin timed_out = 1'b0; break; end
      @(negedge clk125); #1;
    end
  endtask

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk125);
    #1 rstn = 1'b1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", frame_done); end
    checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %0b want 0", frame_ok); end
    checks++; if (frame_len !== '0) begin errors++; $display("FAIL reset_len: got %0d want 0", frame_len); end
    checks++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnts: got good=%0d bad=%0d want 0/0", good_cnt, bad_cnt); end
  endtask

  task automatic test_good_frame();
    bit to; int base, bad_wr;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h88B5, 64);
    drive_frame(frm.size(), -1);
    wait_done(base + 1, to);
    checks++; if (to) begin errors++; $display("FAIL good_timeout: got no frame_done want one"); end
    else begin
      bad_wr = 0;
      for (int k = 0; k < wa_q.size(); k++)
        if (wa_q[k] !== AW'(k) || wd_q[k] !== frm[22+k]) bad_wr++;
      checks++; if (wa_q.size() !== 68) begin errors++; $display("FAIL good_wr_count: got %0d want 68", wa_q.size()); end
      checks++; if (bad_wr !== 0) begin errors++; $display("FAIL good_wr_data: got %0d bad writes want 0", bad_wr); end
      checks++; if (ok_q[$] !== 1'b1) begin errors++; $display("FAIL good_ok: got %0b want 1", ok_q[$]); end
      checks++; if (len_q[$] !== AW'(64)) begin errors++; $display("FAIL good_len: got %0d want 64", len_q[$]); end
      checks++; if (done_cyc <= last_wr_cyc) begin
        errors++; $display("FAIL good_order: done cycle %0d, last write cycle %0d", done_cyc, last_wr_cyc); end
    end
    checks++; if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin
      errors++; $display("FAIL good_cnts: got good=%0d bad=%0d want 1/0", good_cnt, bad_cnt); end
  endtask

  task automatic test_bad_crc();
    bit to; int base;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h88B5, 64);
    frm[22+10] = 8'hEF;
    drive_frame(frm.size(), -1);
    wait_done(base + 1, to);
    checks++; if (to || ok_q[$] !== 1'b0) begin errors++; $display("FAIL badcrc_ok: timeout=%0b got ok=%0b want 0", to, ok_q[$]); end
    checks++; if (len_q[$] !== AW'(64)) begin errors++; $display("FAIL badcrc_len: got %0d want 64", len_q[$]); end
    checks++; if (good_cnt !== 16'd1 || bad_cnt !== 16'd1) begin
      errors++; $display("FAIL badcrc_cnts: got good=%0d bad=%0d want 1/1", good_cnt, bad_cnt); end
  endtask

  task automatic test_filter();
    bit to; int base;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h0800, 64);
    drive_frame(frm.size(), -1);
    wait_done(base + 1, to);
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL type_writes: got %0d want 0", wa_q.size()); end
    checks++; if (to || ok_q[$] !== 1'b0) begin errors++; $display("FAIL type_ok: timeout=%0b got ok=%0b want 0", to, ok_q[$]); end
    checks++; if (bad_cnt !== 16'd2) begin errors++; $display("FAIL type_bad_cnt: got %0d want 2", bad_cnt); end
    base = done_cnt; clear_mon();
    build_frame(BCAST, 16'h88B5, 64);
    drive_frame(frm.size(), -1);
    wait_done(base + 1, to);
    checks++; if (to || ok_q[$] !== 1'b1) begin errors++; $display("FAIL bcast_ok: timeout=%0b got ok=%0b want 1", to, ok_q[$]); end
    checks++; if (wa_q.size() !== 68 || good_cnt !== 16'd2) begin
      errors++; $display("FAIL bcast_wr: got writes=%0d good=%0d want 68/2", wa_q.size(), good_cnt); end
  endtask

  task automatic test_oversize();
    bit to; int base, bad_wr;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h88B5, 1600);
    drive_frame(frm.size(), -1);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL over_early_done: got %0d dones want %0d", done_cnt, base); end
    wait_done(base + 1, to);
    checks++; if (to || ok_q[$] !== 1'b0) begin errors++; $display("FAIL over_ok: timeout=%0b got ok=%0b want 0", to, ok_q[$]); end
    checks++; if (wa_q.size() !== 1504) begin errors++; $display("FAIL over_wr_count: got %0d want 1504", wa_q.size()); end
    else begin
      bad_wr = 0;
      for (int k = 0; k < 1504; k++) if (wa_q[k] !== AW'(k) || wd_q[k] !== frm[22+k]) bad_wr++;
      checks++; if (bad_wr !== 0 || wa_q[$] !== AW'(1503)) begin
        errors++; $display("FAIL over_wr_data: got %0d bad, last addr %0d want 0/1503", bad_wr, wa_q[$]); end
    end
    checks++; if (bad_cnt !== 16'd3) begin errors++; $display("FAIL over_bad_cnt: got %0d want 3", bad_cnt); end
  endtask

  task automatic test_rx_er();
    bit to; int base;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h88B5, 64);
    drive_frame(frm.size(), 22 + 5);
    wait_done(base + 1, to);
    checks++; if (to || ok_q[$] !== 1'b0) begin errors++; $display("FAIL rxer_ok: timeout=%0b got ok=%0b want 0", to, ok_q[$]); end
    checks++; if (wa_q.size() !== 68 || bad_cnt !== 16'd4) begin
      errors++; $display("FAIL rxer_wr: got writes=%0d bad=%0d want 68/4", wa_q.size(), bad_cnt); end
  endtask

  task automatic test_runt();
    bit to; int base;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h88B5, 64);
    drive_frame(8 + 8, -1);
    wait_done(base + 1, to);
    checks++; if (to || ok_q[$] !== 1'b0) begin errors++; $display("FAIL runt_ok: timeout=%0b got ok=%0b want 0", to, ok_q[$]); end
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL runt_writes: got %0d want 0", wa_q.size()); end
    checks++; if (len_q[$] !== '0 || bad_cnt !== 16'd5) begin
      errors++; $display("FAIL runt_len_cnt: got len=%0d bad=%0d want 0/5", len_q[$], bad_cnt); end
  endtask

  task automatic test_back_to_back();
    bit to; int base;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h88B5, 64);
    drive_frame(frm.size(), -1);
    drive_frame(frm.size(), -1);
    wait_done(base + 2, to);
    checks++; if (to || done_cnt !== base + 2) begin errors++; $display("FAIL b2b_dones: got %0d want %0d", done_cnt - base, 2); end
    else begin
      checks++; if (ok_q[$-1] !== 1'b1 || ok_q[$] !== 1'b1) begin
        errors++; $display("FAIL b2b_ok: got %0b,%0b want 1,1", ok_q[$-1], ok_q[$]); end
    end
    checks++; if (good_cnt !== 16'd4 || wa_q.size() !== 136) begin
      errors++; $display("FAIL b2b_cnts: got good=%0d writes=%0d want 4/136", good_cnt, wa_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit to; int base;
    base = done_cnt; clear_mon();
    build_frame(MAC, 16'h88B5, 64);
    for (int i = 0; i < 22 + 20; i++) begin
      @(posedge clk125); #1;
      rx_dv = 1'b1; rx_data = frm[i]; rx_er = 1'b0;
    end
    @(posedge clk125); #1;
    rstn = 1'b0; rx_dv = 1'b0; rx_data = 8'h00;
    @(posedge clk125); #1;
    rstn = 1'b1;
    checks++; if (wr_en !== 1'b0 || frame_ok !== 1'b0 || frame_len !== '0) begin
      errors++; $display("FAIL rstmid_outs: got wr_en=%0b ok=%0b len=%0d want 0", wr_en, frame_ok, frame_len); end
    checks++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_cnts: got good=%0d bad=%0d want 0/0", good_cnt, bad_cnt); end
    repeat (30) @(negedge clk125);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL rstmid_done: got %0d dones want 0", done_cnt - base); end
    drive_frame(frm.size(), -1);
    wait_done(base + 1, to);
    checks++; if (to || ok_q[$] !== 1'b1) begin errors++; $display("FAIL rstmid_next_ok: timeout=%0b got ok=%0b want 1", to, ok_q[$]); end
    checks++; if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_next_cnts: got good=%0d bad=%0d want 1/0", good_cnt, bad_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_filter();
    test_oversize();
    test_rx_er();
    test_runt();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
